// File: rtl/regfile.sv
// regfile: 8 x 16-bit register file, two registered read ports, one write port.
// Ports: I_clk, I_rst (async, active-high), I_en gates all activity, I_we
//   write enable, I_selA/I_selB read indices, I_selD/I_dataD write port,
//   O_dataA/O_dataB registered read data.
// Define REGFILE_BYPASS_EN to forward write data to a read port on the same
//   edge. Without it, a read of the register being written returns old data.
module regfile (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_en,
  input  logic        I_we,
  input  logic [2:0]  I_selA,
  input  logic [2:0]  I_selB,
  input  logic [2:0]  I_selD,
  input  logic [15:0] I_dataD,
  output logic [15:0] O_dataA,
  output logic [15:0] O_dataB
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [15:0] data_a_q, data_a_d;
  logic [15:0] data_b_q, data_b_d;

  always_comb begin
    regs_d   = regs_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (I_en) begin
      data_a_d = regs_q[I_selA];
      data_b_d = regs_q[I_selB];
`ifdef REGFILE_BYPASS_EN
      // Write-through: the port sees this edge's write data.
      if (I_we && (I_selA == I_selD)) data_a_d = I_dataD;
      if (I_we && (I_selB == I_selD)) data_b_d = I_dataD;
`endif
      if (I_we) regs_d[I_selD] = I_dataD;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
      data_a_q <= 16'h0000;
      data_b_q <= 16'h0000;
    end else begin
      regs_q   <= regs_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign O_dataA = data_a_q;
  assign O_dataB = data_b_q;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and random checks of regfile against an
// array-based reference model; mode follows REGFILE_BYPASS_EN.
module tb_regfile;

  logic        I_clk;
  logic        I_rst;
  logic        I_en;
  logic        I_we;
  logic [2:0]  I_selA;
  logic [2:0]  I_selB;
  logic [2:0]  I_selD;
  logic [15:0] I_dataD;
  logic [15:0] O_dataA;
  logic [15:0] O_dataB;

  regfile dut (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_en    (I_en),
    .I_we    (I_we),
    .I_selA  (I_selA),
    .I_selB  (I_selB),
    .I_selD  (I_selD),
    .I_dataD (I_dataD),
    .O_dataA (O_dataA),
    .O_dataB (O_dataB)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [8];
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    exp_a = 16'h0000;
    exp_b = 16'h0000;
  endtask

  // Reference behaviour of one rising edge, using the inputs applied.
  task automatic model_edge();
    logic [15:0] na;
    logic [15:0] nb;
    if (I_rst || !I_en) return;
    na = mem[I_selA];
    nb = mem[I_selB];
`ifdef REGFILE_BYPASS_EN
    if (I_we && I_selA == I_selD) na = I_dataD;
    if (I_we && I_selB == I_selD) nb = I_dataD;
`endif
    if (I_we) mem[I_selD] = I_dataD;
    exp_a = na;
    exp_b = nb;
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (O_dataA === exp_a) else begin
      n_fail++;
      $error("FAIL %s A: got %h want %h", tag, O_dataA, exp_a);
    end
    n_checks++;
    assert (O_dataB === exp_b) else begin
      n_fail++;
      $error("FAIL %s B: got %h want %h", tag, O_dataB, exp_b);
    end
  endtask

  task automatic step(
    input logic        en,
    input logic        we,
    input logic [2:0]  a,
    input logic [2:0]  b,
    input logic [2:0]  d,
    input logic [15:0] data,
    input string       tag
  );
    I_en    = en;
    I_we    = we;
    I_selA  = a;
    I_selB  = b;
    I_selD  = d;
    I_dataD = data;
    @(posedge I_clk);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    I_rst   = 1'b1;
    I_en    = 1'b0;
    I_we    = 1'b0;
    I_selA  = 3'd0;
    I_selB  = 3'd0;
    I_selD  = 3'd0;
    I_dataD = 16'h0000;
    model_reset();
    #12;
    check("reset");
    I_rst = 1'b0;

    // Basic write/read
    step(1, 1, 3'd0, 3'd1, 3'd0, 16'hFFFF, "wr_r0");
    step(1, 0, 3'd0, 3'd1, 3'd0, 16'h0000, "rd_r0");
    // Overwrite
    step(1, 1, 3'd2, 3'd0, 3'd2, 16'h2222, "ow1");
    step(1, 1, 3'd2, 3'd0, 3'd2, 16'h3333, "ow2");
    step(1, 0, 3'd2, 3'd2, 3'd0, 16'h0000, "ow_rd");
    // Write disable
    for (int i = 0; i < 3; i++)
      step(1, 0, 3'd0, 3'd0, 3'd0, 16'hFEED, "we0");
    // Dual port same index
    step(1, 1, 3'd1, 3'd1, 3'd4, 16'h4444, "wr_r4");
    step(1, 0, 3'd4, 3'd4, 3'd0, 16'h0000, "dual");
    // Enable gating
    for (int i = 0; i < 4; i++)
      step(0, 1, 3'(i), 3'(7 - i), 3'd5, 16'h5555, "en0");
    step(1, 0, 3'd5, 3'd5, 3'd0, 16'h0000, "en_rd");
    // Same-edge read of written register
    step(1, 1, 3'd3, 3'd3, 3'd3, 16'hABCD, "byp");
    step(1, 0, 3'd3, 3'd0, 3'd0, 16'h0000, "byp_rd");

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 7) != 0), 1'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom),
           16'($urandom), "rand");

    // Asynchronous reset mid-run
    step(1, 1, 3'd6, 3'd7, 3'd6, 16'h6666, "pre_rst");
    I_rst = 1'b1;
    model_reset();
    #1;
    check("rst_async");
    step(1, 1, 3'd6, 3'd6, 3'd6, 16'h7777, "rst_edge");
    I_rst = 1'b0;
    for (int i = 0; i < 8; i++)
      step(1, 0, 3'(i), 3'(7 - i), 3'd0, 16'h0000, "rst_rd");

    // More random after reset
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 3) != 0), 1'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom),
           16'($urandom), "rand2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
